// File: rtl/sub_serial.sv
// Bit-serial subtractor: o_diff = i_a - i_b - i_bin, LSB first, one full-adder slice plus a carry flop.
// Optional signed-overflow output o_ovf is enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               c_q, c_d;
    logic               bout_q, bout_d;
`ifdef SUB_SERIAL_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               sum_bit;
    logic               carry_next;
    logic               last_bit;

    // Subtraction as a + ~b + ~bin: the carry flop is seeded with the inverted borrow-in.
    assign sum_bit    = a_q[0] ^ nb_q[0] ^ c_q;
    assign carry_next = (a_q[0] & nb_q[0]) | (a_q[0] & c_q) | (nb_q[0] & c_q);
    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUB_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    nb_d    = ~i_b;
                    c_d     = ~i_bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                nb_d  = nb_q >> 1;
                c_d   = carry_next;
                res_d = {sum_bit, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    diff_d  = {sum_bit, res_q[WIDTH-1:1]};
                    bout_d  = ~carry_next;
`ifdef SUB_SERIAL_OVF_EN
                    // Carry into the MSB differs from carry out of it exactly on signed overflow.
                    ovf_d   = c_q ^ carry_next;
`endif
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves no stale result visible.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            nb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUB_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_valid = (state_q == S_DONE);
    assign o_diff  = diff_q;
    assign o_bout  = bout_q;
`ifdef SUB_SERIAL_OVF_EN
    assign o_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed vector table on WIDTH=4, handshake/reset
// sequences, and a randomly stalled WIDTH=8 stream against an arithmetic reference.
module tb_sub_serial;

    logic clk;
    logic rst_n;

    // WIDTH=4 instance
    logic       v4_i, rdy4_o, v4_o, rdy4_i, bin4, bout4;
    logic [3:0] a4, b4, diff4;
`ifdef SUB_SERIAL_OVF_EN
    logic       ovf4;
`endif

    // WIDTH=8 instance
    logic       v8_i, rdy8_o, v8_o, rdy8_i, bin8, bout8;
    logic [7:0] a8, b8, diff8;
`ifdef SUB_SERIAL_OVF_EN
    logic       ovf8;
`endif

    int errors = 0;
    int checks = 0;

    sub_serial #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rstn(rst_n), .i_valid(v4_i), .o_ready(rdy4_o),
        .i_a(a4), .i_b(b4), .i_bin(bin4), .o_valid(v4_o), .i_ready(rdy4_i),
        .o_diff(diff4), .o_bout(bout4)
`ifdef SUB_SERIAL_OVF_EN
        , .o_ovf(ovf4)
`endif
    );

    sub_serial #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rstn(rst_n), .i_valid(v8_i), .o_ready(rdy8_o),
        .i_a(a8), .i_b(b8), .i_bin(bin8), .o_valid(v8_o), .i_ready(rdy8_i),
        .o_diff(diff8), .o_bout(bout8)
`ifdef SUB_SERIAL_OVF_EN
        , .o_ovf(ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for o_ready, accept one operand set on dut4, then wait for o_valid and check latency.
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic bin, input string tag);
        int guard;
        int lat;
        guard = 0;
        @(negedge clk);
        while (!rdy4_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " ready before accept"}, 32'(rdy4_o), 32'd1);
        a4   = a;
        b4   = b;
        bin4 = bin;
        v4_i = 1'b1;
        @(posedge clk);
        #1;
        v4_i = 1'b0;
        lat  = 0;
        while (!v4_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency (edges after accept)"}, 32'(lat), 32'd4);
    endtask

    task automatic retire4(input string tag);
        @(negedge clk);
        rdy4_i = 1'b1;
        @(posedge clk);
        #1;
        rdy4_i = 1'b0;
        check({tag, " valid drops after retire"}, 32'(v4_o), 32'd0);
        check({tag, " ready after retire"}, 32'(rdy4_o), 32'd1);
    endtask

    initial begin
        vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1};
        vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0};
        vecs[3] = '{4'd5,  4'd2,  1'b0, 4'd3,  1'b0, 1'b0};
        vecs[4] = '{4'd0,  4'd1,  1'b0, 4'hF,  1'b1, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 4'hF,  1'b1, 1'b0};
        vecs[6] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
        vecs[7] = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};

        rst_n  = 1'b0;
        v4_i   = 1'b0; rdy4_i = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        v8_i   = 1'b0; rdy8_i = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        #22;
        check("reset ready", 32'(rdy4_o), 32'd1);
        check("reset valid", 32'(v4_o), 32'd0);
        check("reset diff", 32'(diff4), 32'd0);
        check("reset bout", 32'(bout4), 32'd0);
`ifdef SUB_SERIAL_OVF_EN
        check("reset ovf", 32'(ovf4), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_op4(vecs[i].a, vecs[i].b, vecs[i].bin, tag);
            check({tag, " valid"}, 32'(v4_o), 32'd1);
            check({tag, " diff"}, 32'(diff4), 32'(vecs[i].diff));
            check({tag, " bout"}, 32'(bout4), 32'(vecs[i].bout));
`ifdef SUB_SERIAL_OVF_EN
            check({tag, " ovf"}, 32'(ovf4), 32'(vecs[i].ovf));
`endif
            retire4(tag);
            check({tag, " diff held after retire"}, 32'(diff4), 32'(vecs[i].diff));
        end

        // Backpressure: hold DONE for 10 cycles, ignoring i_valid meanwhile
        do_op4(4'd9, 4'd3, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            v4_i = (i % 2 == 0);
            a4   = 4'(i);
            check($sformatf("bp stall%0d valid", i), 32'(v4_o), 32'd1);
            check($sformatf("bp stall%0d ready", i), 32'(rdy4_o), 32'd0);
            check($sformatf("bp stall%0d diff/bout", i), 32'({bout4, diff4}), 32'({1'b0, 4'd6}));
        end
        // Retire with i_valid also high: must not accept in the same cycle
        @(negedge clk);
        v4_i   = 1'b1;
        rdy4_i = 1'b1;
        @(posedge clk);
        #1;
        v4_i   = 1'b0;
        rdy4_i = 1'b0;
        check("bp valid drops", 32'(v4_o), 32'd0);
        check("bp ready returns", 32'(rdy4_o), 32'd1);
        @(posedge clk);
        #1;
        check("bp no accept during retire", 32'(rdy4_o), 32'd1);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd1; bin4 = 1'b0; v4_i = 1'b1;
        @(posedge clk);
        #1;
        v4_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid-op diff nonzero before reset", 32'(diff4 != 4'd0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset ready", 32'(rdy4_o), 32'd1);
        check("async reset valid", 32'(v4_o), 32'd0);
        check("async reset diff", 32'(diff4), 32'd0);
        check("async reset bout", 32'(bout4), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op4(4'd5, 4'd2, 1'b0, "post-reset");
        check("post-reset diff", 32'(diff4), 32'd3);
        check("post-reset bout", 32'(bout4), 32'd0);
        retire4("post-reset");

        // Randomly stalled WIDTH=8 stream against the arithmetic reference
        begin
            logic [8:0] exp_q[$];
            logic [8:0] ref_val;
            int issued;
            int got;
            int cyc;
            issued = 0;
            got    = 0;
            cyc    = 0;
            while (got < 1000 && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                rdy8_i = ($urandom_range(0, 2) != 0);
                if (v8_o && rdy8_i) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL rand duplicate: got 0x%0h expected none", {bout8, diff8});
                    end else begin
                        ref_val = exp_q.pop_front();
                        check($sformatf("rand op%0d {bout,diff}", got), 32'({bout8, diff8}), 32'(ref_val));
                    end
                    got++;
                end
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                bin8 = 1'($urandom);
                if (rdy8_o) begin
                    v8_i = (issued < 1000) && ($urandom_range(0, 1) == 1);
                    if (v8_i) begin
                        exp_q.push_back({1'b0, a8} - {1'b0, b8} - 9'(bin8));
                        issued++;
                    end
                end else begin
                    v8_i = ($urandom_range(0, 3) == 0);
                end
            end
            v8_i   = 1'b0;
            rdy8_i = 1'b0;
            check("rand results received", 32'(got), 32'd1000);
            check("rand results outstanding", 32'(exp_q.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
